// File: rtl/uart_tx_parity.sv
// uart_tx_parity: UART transmitter with optional even/odd parity and run-time bit period
module uart_tx_parity #(
  parameter int   WIDTH      = 8,
  parameter logic EVEN       = 1'b0,
  parameter logic ODD        = 1'b1,
  parameter int   PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  logic [2:0]            state;
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] pr_q;
  logic [IW-1:0]         bit_idx;
  logic [WIDTH-1:0]      sh;
  logic                  par_en_q;
  logic                  par_q;
  logic                  tx_q;
  logic                  last_cycle;
  logic                  accept;
  logic                  par_calc;
  always_comb begin
    last_cycle = cnt == pr_q - 1'b1;
    tx_ready   = state == IDLE || (state == STOP && last_cycle);
    accept     = tx_valid && tx_ready;
    busy       = state != IDLE;
    tx_out     = tx_q;
    par_calc   = par_type == EVEN ? ^tx_data : par_type == ODD ? ~^tx_data : ^tx_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pr_q     <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      if (accept) begin
        sh       <= tx_data;
        par_en_q <= par_en;
        par_q    <= par_calc;
        pr_q     <= prescale == '0 ? PRESCALE_W'(1) : prescale;
      end
      cnt <= (state == IDLE || last_cycle) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (accept) begin
          state <= START;
          tx_q  <= 1'b0;
        end
        START: if (last_cycle) begin
          state        <= DATA;
          bit_idx      <= '0;
          {sh, tx_q}   <= {1'b0, sh};
        end
        DATA: if (last_cycle) begin
          if (bit_idx == IW'(WIDTH - 1)) begin
            state <= par_en_q ? PARITY : STOP;
            tx_q  <= par_en_q ? par_q : 1'b1;
          end else begin
            bit_idx    <= bit_idx + 1'b1;
            {sh, tx_q} <= {1'b0, sh};
          end
        end
        PARITY: if (last_cycle) begin
          state <= STOP;
          tx_q  <= 1'b1;
        end
        STOP: if (last_cycle) begin
          state <= accept ? START : IDLE;
          tx_q  <= !accept;
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_parity.sv
// tb_uart_tx_parity: scoreboard bench decoding the serial line against a frame-level model
module tb_uart_tx_parity;
  localparam int W = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        par_en = 1'b0;
  logic        par_type = 1'b0;
  logic [15:0] prescale = '0;
  logic        tx_ready;
  logic        tx_out;
  logic        busy;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  typedef struct {
    logic [W-1:0] d;
    bit           pe;
    bit           pt;
    int           pr;
    int           c;
  } exp_t;
  exp_t q[$];
  uart_tx_parity #(.WIDTH(W), .EVEN(1'b0), .ODD(1'b1), .PRESCALE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .par_en(par_en), .par_type(par_type), .prescale(prescale), .tx_out(tx_out), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  initial begin
    exp_t e;
    int nb, len, idx;
    bit fb[0:W+2];
    logic [W-1:0] rx;
    logic rp;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n && !tx_out) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: got start bit expected idle line at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          nb = 2 + W + int'(e.pe);
          len = nb * e.pr;
          fb[0] = 1'b0;
          for (int i = 0; i < W; i++) fb[1 + i] = e.d[i];
          if (e.pe) fb[W + 1] = e.pt ? ~^e.d : ^e.d;
          fb[nb - 1] = 1'b1;
          rx = '0;
          rp = 1'b0;
          aborted = 1'b0;
          chk("start_cycle", cyc, e.c);
          for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            chk("tx_bit", tx_out, fb[i / e.pr]);
            chk("busy_in_frame", busy, 1);
            chk("tx_ready_in_frame", tx_ready, i == len - 1);
            if (i % e.pr == e.pr / 2) begin
              idx = i / e.pr;
              if (idx >= 1 && idx <= W) rx[idx - 1] = tx_out;
              if (e.pe && idx == W + 1) rp = tx_out;
            end
          end
          if (aborted) q.delete();
          else begin
            chk("rx_word", rx, e.d);
            if (e.pe) chk("rx_parity_err", rp != (e.pt ? ~^rx : ^rx), 0);
          end
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [W-1:0] d, input bit pe, input bit pt, input int ps);
    tx_data = d;
    par_en = pe;
    par_type = pt;
    prescale = 16'(ps);
    tx_valid = 1'b1;
    for (int t = 0; t < 2000 && !tx_ready; t++) step(1);
    if (!tx_ready) begin
      chk("ready_timeout", tx_ready, 1);
      tx_valid = 1'b0;
      return;
    end
    q.push_back('{d, pe, pt, ps == 0 ? 1 : ps, cyc + 1});
    step(1);
  endtask
  task automatic drain();
    tx_valid = 1'b0;
    for (int t = 0; t < 5000 && (q.size() != 0 || busy); t++) step(1);
    chk("drain_done", q.size() == 0 && !busy, 1);
    chk("idle_tx_out", tx_out, 1);
    chk("idle_tx_ready", tx_ready, 1);
  endtask
  initial begin
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("reset_tx_out", tx_out, 1);
      chk("reset_tx_ready", tx_ready, 1);
      chk("reset_busy", busy, 0);
      step(1);
    end
    send(8'hA5, 1'b1, 1'b0, 4);
    drain();
    send(8'h07, 1'b1, 1'b1, 2);
    drain();
    send(8'h00, 1'b0, 1'b0, 0);
    send(8'hFF, 1'b0, 1'b0, 0);
    drain();
    send(8'h3C, 1'b1, 1'b0, 3);
    tx_valid = 1'b0;
    tx_data = 8'hC3;
    prescale = 16'd1;
    par_type = 1'b1;
    par_en = 1'b0;
    step(9);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("post_reset_tx_out", tx_out, 1);
    chk("post_reset_tx_ready", tx_ready, 1);
    chk("post_reset_busy", busy, 0);
    step(3);
    chk("post_reset_queue", q.size(), 0);
    for (int n = 0; n < 256; n++) begin
      send(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) begin
        tx_valid = 1'b0;
        step(int'($urandom_range(1, 5)));
      end
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
